alu_result_select_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 8:1 ALU result multiplexer.
- Selects one of NUM_IN signed result channels per transaction and registers it into a 2-entry skid buffer.
- Uses a valid/ready handshake on both sides, so it can sit between the ALU function units and the writeback/display stage without breaking throughput.
- Adds out-of-range select detection and optional result flags.

---
 rtl/alu_result_select_pipe_if.sv | 45 ++++
 rtl/alu_result_select_pipe.sv | 142 ++++++++++++++
 tb/tb_alu_result_select_pipe.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_select_pipe_if.sv
// Handshake bundle for alu_result_select_pipe: flattened input channels, select,
// and the skid-buffer output side. The optional flag signals exist only when
// MUX_FLAGS_EN is defined.
interface alu_result_select_pipe_if #(
  parameter int N      = 4,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
);
  logic [NUM_IN*(N+2)-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [N+1:0]     out_data;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
`ifdef MUX_FLAGS_EN
  logic                    out_zero;
  logic                    out_neg;

  // Producer/consumer side (testbench or surrounding pipeline)
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid, out_zero, out_neg
  );

  // Block side
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid, out_zero, out_neg
  );
`else
  // Producer/consumer side (testbench or surrounding pipeline)
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  // Block side
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
`endif
endinterface

// File: rtl/alu_result_select_pipe.sv
// alu_result_select_pipe: selects one of NUM_IN signed (N+2)-bit channels per
// accepted transaction and stores it in a 2-entry skid buffer (strict FIFO).
// Selects >= NUM_IN store an all-zero word tagged with err.
// Optional feature macro: MUX_FLAGS_EN adds per-entry zero/negative flags,
// computed at capture time and presented with the head entry.
// in_ready and out_valid are registered functions of buffer occupancy only.
module alu_result_select_pipe #(
  parameter int N      = 4,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_result_select_pipe_if.slave  pipe_if
);

  localparam int W = N + 2;

  // One buffered transaction
  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
`ifdef MUX_FLAGS_EN
    logic         zero;
    logic         neg;
`endif
  } entry_t;

  // Occupancy of the skid buffer
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b10
  } state_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   in_ready_q;
  logic   out_valid_q;
  entry_t new_entry_s;
  logic   push_s;
  logic   pop_s;

  // Build the word captured on a push; out-of-range selects yield zero + err
  function automatic entry_t make_entry(input logic [NUM_IN*W-1:0] bus,
                                        input logic [SEL_W-1:0]    sel);
    entry_t e;
    e = '0;
    e.err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) begin
        e.data = bus[k*W +: W];
        e.err  = 1'b0;
      end else begin
        e.data = e.data;
      end
    end
`ifdef MUX_FLAGS_EN
    e.zero = (e.data == '0);
    e.neg  = e.data[W-1];
`endif
    return e;
  endfunction

  assign push_s      = pipe_if.in_valid && in_ready_q;
  assign pop_s       = out_valid_q && pipe_if.out_ready;
  assign new_entry_s = make_entry(pipe_if.in_data, pipe_if.in_sel);

  // Next occupancy and entry contents from push/pop of this cycle
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      S_EMPTY: begin
        if (push_s) begin
          state_d = S_ONE;
          head_d  = new_entry_s;
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_ONE: begin
        if (push_s && pop_s) begin
          // Head leaves and the new word replaces it in the same cycle
          state_d = S_ONE;
          head_d  = new_entry_s;
        end else if (push_s) begin
          state_d = S_FULL;
          tail_d  = new_entry_s;
        end else if (pop_s) begin
          state_d = S_EMPTY;
          head_d  = '0;
        end else begin
          state_d = S_ONE;
        end
      end
      S_FULL: begin
        if (pop_s) begin
          state_d = S_ONE;
          head_d  = tail_q;
          tail_d  = '0;
        end else begin
          state_d = S_FULL;
        end
      end
      default: begin
        state_d = S_EMPTY;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
  end

  // State, storage and registered handshake outputs; reset flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
    end
  end

  assign pipe_if.in_ready  = in_ready_q;
  assign pipe_if.out_valid = out_valid_q;
  assign pipe_if.out_data  = head_q.data;
  assign pipe_if.out_err   = head_q.err;
`ifdef MUX_FLAGS_EN
  assign pipe_if.out_zero  = head_q.zero;
  assign pipe_if.out_neg   = head_q.neg;
`endif

endmodule

// File: tb/tb_alu_result_select_pipe.sv
// Self-checking bench: two instances (8 channels and 6 channels) driven with the
// same stimulus and checked against a queue-based reference model, plus a
// vector table and hand-written backpressure/reset/hold sequences.
module tb_alu_result_select_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_result_select_pipe_if #(.N(4), .NUM_IN(8), .SEL_W(3)) if8 ();
  alu_result_select_pipe_if #(.N(4), .NUM_IN(6), .SEL_W(3)) if6 ();

  alu_result_select_pipe #(.N(4), .NUM_IN(8), .SEL_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .pipe_if(if8));
  alu_result_select_pipe #(.N(4), .NUM_IN(6), .SEL_W(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .pipe_if(if6));

  typedef struct {
    logic [5:0] data;
    bit         err;
  } ent_t;

  typedef struct {
    int         sel;
    logic [5:0] val;
    logic [5:0] d8;
    bit         e8;
    logic [5:0] d6;
    bit         e6;
    bit         z8;
    bit         n8;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ch[8];
  int   sel;
  bit   ivalid;
  bit   ordy;
  bit   started;
  ent_t q8[$];
  ent_t q6[$];
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of one capture: channel value or zero + err
  function automatic ent_t pick(input int num_in);
    ent_t e;
    if (sel < num_in) begin
      e.data = ch[sel][5:0];
      e.err  = 1'b0;
    end else begin
      e.data = 6'd0;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  task automatic drive();
    logic [47:0] bus;
    for (int k = 0; k < 8; k++) bus[k*6 +: 6] = ch[k][5:0];
    if8.in_data   = bus;
    if6.in_data   = bus[35:0];
    if8.in_sel    = sel[2:0];
    if6.in_sel    = sel[2:0];
    if8.in_valid  = ivalid;
    if6.in_valid  = ivalid;
    if8.out_ready = ordy;
    if6.out_ready = ordy;
  endtask

  task automatic cmp_dut(input string tag, input int qsz, input ent_t head,
                         input logic irdy, input logic ovld, input logic [5:0] odata,
                         input logic oerr, input logic ozero, input logic oneg);
    check({tag, ".in_ready"}, irdy, (started && qsz < 2));
    check({tag, ".out_valid"}, ovld, (qsz > 0));
    if (qsz > 0) begin
      check({tag, ".out_data"}, odata, head.data);
      check({tag, ".out_err"}, oerr, head.err);
`ifdef MUX_FLAGS_EN
      check({tag, ".out_zero"}, ozero, (head.data == 6'd0));
      check({tag, ".out_neg"}, oneg, (head.data[5] && !head.err));
`endif
    end
  endtask

  task automatic cmp_all(input string tag);
    ent_t h8, h6;
    logic z8, n8, z6, n6;
    h8 = '{6'd0, 1'b0};
    h6 = '{6'd0, 1'b0};
    if (q8.size() > 0) h8 = q8[0];
    if (q6.size() > 0) h6 = q6[0];
`ifdef MUX_FLAGS_EN
    z8 = if8.out_zero; n8 = if8.out_neg; z6 = if6.out_zero; n6 = if6.out_neg;
`else
    z8 = 1'b0; n8 = 1'b0; z6 = 1'b0; n6 = 1'b0;
`endif
    cmp_dut({tag, "/d8"}, q8.size(), h8, if8.in_ready, if8.out_valid,
            $unsigned(if8.out_data), if8.out_err, z8, n8);
    cmp_dut({tag, "/d6"}, q6.size(), h6, if6.in_ready, if6.out_valid,
            $unsigned(if6.out_data), if6.out_err, z6, n6);
  endtask

  // One clock: apply inputs, advance the model, compare after the edge
  task automatic step(input string tag);
    bit   push8, pop8, push6, pop6;
    ent_t e8, e6;
    drive();
    push8 = ivalid && started && (q8.size() < 2);
    pop8  = ordy && (q8.size() > 0);
    push6 = ivalid && started && (q6.size() < 2);
    pop6  = ordy && (q6.size() > 0);
    e8 = pick(8);
    e6 = pick(6);
    @(posedge clk);
    #1;
    if (pop8) void'(q8.pop_front());
    if (push8) q8.push_back(e8);
    if (pop6) void'(q6.pop_front());
    if (push6) q6.push_back(e6);
    started = 1'b1;
    cmp_all(tag);
  endtask

  // Async reset assertion, checks, then release away from the clock edge
  task automatic do_reset(input string tag);
    rst_n  = 1'b0;
    ivalid = 1'b0;
    ordy   = 1'b0;
    drive();
    #1;
    q8.delete();
    q6.delete();
    started = 1'b0;
    check({tag, ".rst.valid8"}, if8.out_valid, 1'b0);
    check({tag, ".rst.data8"}, $unsigned(if8.out_data), 6'd0);
    check({tag, ".rst.err8"}, if8.out_err, 1'b0);
    check({tag, ".rst.ready8"}, if8.in_ready, 1'b0);
    check({tag, ".rst.valid6"}, if6.out_valid, 1'b0);
    check({tag, ".rst.data6"}, $unsigned(if6.out_data), 6'd0);
`ifdef MUX_FLAGS_EN
    check({tag, ".rst.zero8"}, if8.out_zero, 1'b0);
    check({tag, ".rst.neg8"}, if8.out_neg, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, ".rel.ready8"}, if8.in_ready, 1'b0);
    check({tag, ".rel.ready6"}, if6.in_ready, 1'b0);
  endtask

  initial begin
    logic [5:0] hold_v;
    logic [5:0] exp_v;
    tbl[0] = '{3, -6'sd5,  -6'sd5,  1'b0, -6'sd5,  1'b0, 1'b0, 1'b1};
    tbl[1] = '{7, 6'sd9,   6'sd9,   1'b0, 6'd0,    1'b1, 1'b0, 1'b0};
    tbl[2] = '{6, -6'sd32, -6'sd32, 1'b0, 6'd0,    1'b1, 1'b0, 1'b1};
    tbl[3] = '{0, 6'sd31,  6'sd31,  1'b0, 6'sd31,  1'b0, 1'b0, 1'b0};
    tbl[4] = '{5, 6'sd0,   6'sd0,   1'b0, 6'sd0,   1'b0, 1'b1, 1'b0};
    tbl[5] = '{2, -6'sd1,  -6'sd1,  1'b0, -6'sd1,  1'b0, 1'b0, 1'b1};

    for (int k = 0; k < 8; k++) ch[k] = 0;
    sel = 0;
    do_reset("init");
    step("idle");

    // Single transactions from an empty buffer
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) ch[k] = int'($urandom_range(0, 63)) - 32;
      ch[tbl[i].sel] = int'($signed(tbl[i].val));
      sel    = tbl[i].sel;
      ivalid = 1'b1;
      ordy   = 1'b1;
      step("tbl");
      check("tbl.data8", $unsigned(if8.out_data), tbl[i].d8);
      check("tbl.err8", if8.out_err, tbl[i].e8);
      check("tbl.data6", $unsigned(if6.out_data), tbl[i].d6);
      check("tbl.err6", if6.out_err, tbl[i].e6);
`ifdef MUX_FLAGS_EN
      check("tbl.zero8", if8.out_zero, tbl[i].z8);
      check("tbl.neg8", if8.out_neg, tbl[i].n8);
      check("tbl.zero6", if6.out_zero, tbl[i].e6 ? 1'b1 : tbl[i].z8);
`endif
      ivalid = 1'b0;
      step("tbl.pop");
    end

    // Backpressure: fill to FULL, third offer refused, then drain
    ordy = 1'b0; ivalid = 1'b1; sel = 1;
    ch[1] = 31;  step("bp1");
    ch[1] = -32; step("bp2");
    check("bp.full_ready", if8.in_ready, 1'b0);
    ch[1] = 7;   step("bp3");
    check("bp.head31", $unsigned(if8.out_data), 6'd31);
    ivalid = 1'b0; ordy = 1'b1;
    step("bp4");
    check("bp.head_m32", $unsigned(if8.out_data), 6'b100000);
    check("bp.ready_back", if8.in_ready, 1'b1);
    step("bp5");
    check("bp.no_7", if8.out_valid, 1'b0);

    // Back-to-back sweep at full throughput
    for (int k = 0; k < 8; k++) ch[k] = k - 4;
    ivalid = 1'b1; ordy = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = s;
      step("sweep");
      exp_v = 6'(s - 4);
      check("sweep.data8", $unsigned(if8.out_data), exp_v);
      check("sweep.valid8", if8.out_valid, 1'b1);
    end
    ivalid = 1'b0;
    step("sweep.drain");

    // Reset while FULL discards both entries
    ordy = 1'b0; ivalid = 1'b1; sel = 2;
    ch[2] = 10; step("rf1");
    ch[2] = 11; step("rf2");
    #3;
    do_reset("midrst");
    step("midrst.idle1");
    check("midrst.ready", if8.in_ready, 1'b1);
    ordy = 1'b1;
    step("midrst.idle2");
    check("midrst.no_stale", if8.out_valid, 1'b0);

    // Head held while inputs toggle without a push
    ordy = 1'b0; ivalid = 1'b1; sel = 4; ch[4] = -7;
    step("hold.push");
    hold_v = 6'(-7);
    ivalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 8; k++) ch[k] = int'($urandom_range(0, 63)) - 32;
      sel = int'($urandom_range(0, 7));
      step("hold");
      check("hold.data8", $unsigned(if8.out_data), hold_v);
    end
    ordy = 1'b1;
    step("hold.pop");

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 8; k++) ch[k] = int'($urandom_range(0, 63)) - 32;
      sel    = int'($urandom_range(0, 7));
      ivalid = ($urandom_range(0, 3) != 0);
      ordy   = ($urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
